// File: rtl/ssqa_pkg.sv
// Shared definitions for the SSQA annealing controller: FSM state
// encodings and the spin-counter width helper.
package ssqa_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RESET  = 4'd1,
    S_MULT   = 4'd3,
    S_LMULT  = 4'd4,
    S_UPDATE = 4'd7,
    S_IRESET = 4'd9,
    S_FIN    = 4'd10
  } state_t;

  localparam int unsigned ADDR_W = 20;

  // Width of a counter that indexes n spins; the top derives SPIN_W from it.
  function automatic int unsigned spin_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ssqa_controller_q_schedule.sv
// Temperature (Q) schedule arithmetic, purely combinational.
//   mode, beta, q, qmin, qmax : current level and latched schedule settings
//   q_init_c : starting level (clamped to qmax when qmin >= qmax)
//   q_step_c : next level, linear (mode 0) or exponential approach (mode 1)
module q_schedule
  import ssqa_pkg::*;
#(
  parameter int unsigned TEM_WIDTH = 8
) (
  input  logic                 mode,
  input  logic [3:0]           beta,
  input  logic [TEM_WIDTH-1:0] q,
  input  logic [TEM_WIDTH-1:0] qmin,
  input  logic [TEM_WIDTH-1:0] qmax,
  output logic [TEM_WIDTH-1:0] q_init_c,
  output logic [TEM_WIDTH-1:0] q_step_c
);

  // One guard bit so q + increment can never wrap before the clamp.
  localparam int unsigned GW = TEM_WIDTH + 1;

  logic [GW-1:0] q_g;
  logic [GW-1:0] qmax_g;
  logic [GW-1:0] diff_g;
  logic [GW-1:0] inc_g;
  logic [GW-1:0] sum_g;

  always_comb begin
    q_g    = GW'(q);
    qmax_g = GW'(qmax);
    diff_g = (q_g >= qmax_g) ? '0 : (qmax_g - q_g);
    if (mode) begin
      inc_g = diff_g >> beta;
      if (inc_g == '0) inc_g = GW'(1);
    end else begin
      inc_g = (beta == 4'd0) ? GW'(1) : GW'(beta);
    end
    sum_g    = q_g + inc_g;
    q_step_c = (sum_g > qmax_g) ? qmax : sum_g[TEM_WIDTH-1:0];
    q_init_c = (qmin >= qmax) ? qmax : qmin;
  end

endmodule

// File: rtl/ssqa_controller.sv
// SSQA annealing sequencer: walks the J matrix row by row for every spin,
// steps the temperature Q through its schedule and repeats for several runs.
//   clk, rst_sys (sync, active-high), comp_en (rising edge starts), abort
//   tau, beta, Qmin, Qmax, runs, mode : job configuration, latched at start
//   en_read/en_mult/en_upd/rst_iter/rst_ini : BRAM and spin-array strobes
//   count_addr/count_spin/count_iter, Q, state, run_idx, busy, done : status
module ssqa_controller
  import ssqa_pkg::*;
#(
  parameter int unsigned N          = 800,
  parameter int unsigned M          = 20,
  parameter int unsigned TEM_WIDTH  = 8,
  parameter int unsigned ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_sys,
  input  logic                  comp_en,
  input  logic                  abort,
  input  logic [7:0]            tau,
  input  logic [3:0]            beta,
  input  logic [TEM_WIDTH-1:0]  Qmin,
  input  logic [TEM_WIDTH-1:0]  Qmax,
  input  logic [7:0]            runs,
  input  logic                  mode,
  output logic                  en_read,
  output logic                  en_mult,
  output logic                  en_upd,
  output logic                  rst_iter,
  output logic                  rst_ini,
  output logic [19:0]           count_addr,
  output logic [$clog2(N)-1:0]  count_spin,
  output logic [ITER_WIDTH-1:0] count_iter,
  output logic [TEM_WIDTH-1:0]  Q,
  output logic [3:0]            state,
  output logic [7:0]            run_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SPIN_W = spin_w(N);
  localparam logic [ADDR_W-1:0] N_A = ADDR_W'(N);
  localparam logic [SPIN_W-1:0] LAST_IDX = SPIN_W'(N - 1);

  // Elaboration-time parameter sanity checks.
  if (N < 2 || (N * N) > (1 << ADDR_W)) begin : g_bad_n
    $error("ssqa_controller: N must satisfy 2 <= N and N*N <= 2^20");
  end
  if (M < 1) begin : g_bad_m
    $error("ssqa_controller: M must be at least 1");
  end

  state_t state_q, state_n;

  logic                  comp_en_q;
  logic [SPIN_W-1:0]     col_q, col_n;
  logic                  drain_q, drain_n;
  logic [7:0]            sweep_q, sweep_n;
  logic [SPIN_W-1:0]     spin_n;
  logic [ITER_WIDTH-1:0] iter_n;
  logic [TEM_WIDTH-1:0]  q_n;
  logic [7:0]            run_n;

  logic [7:0]            tau_q, tau_n;
  logic [3:0]            beta_q, beta_n;
  logic [TEM_WIDTH-1:0]  qmin_q, qmin_n;
  logic [TEM_WIDTH-1:0]  qmax_q, qmax_n;
  logic [7:0]            runs_q, runs_n;
  logic                  mode_q, mode_n;

  logic [7:0]            tau_eff;
  logic [7:0]            last_run;
  logic [TEM_WIDTH-1:0]  q_init_c;
  logic [TEM_WIDTH-1:0]  q_step_c;

  // Zero tau/runs mean one sweep per level / one run.
  assign tau_eff  = (tau_q == 8'd0) ? 8'd1 : tau_q;
  assign last_run = (runs_q == 8'd0) ? 8'd0 : (runs_q - 8'd1);
  assign state    = state_q;

  q_schedule #(
    .TEM_WIDTH (TEM_WIDTH)
  ) u_q_schedule (
    .mode     (mode_q),
    .beta     (beta_q),
    .q        (Q),
    .qmin     (qmin_q),
    .qmax     (qmax_q),
    .q_init_c (q_init_c),
    .q_step_c (q_step_c)
  );

  // Next-state and next-datapath logic.
  always_comb begin
    state_n = state_q;
    col_n   = col_q;
    drain_n = drain_q;
    sweep_n = sweep_q;
    spin_n  = count_spin;
    iter_n  = count_iter;
    q_n     = Q;
    run_n   = run_idx;
    tau_n   = tau_q;
    beta_n  = beta_q;
    qmin_n  = qmin_q;
    qmax_n  = qmax_q;
    runs_n  = runs_q;
    mode_n  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (comp_en && !comp_en_q) begin
          state_n = S_RESET;
          tau_n   = tau;
          beta_n  = beta;
          qmin_n  = Qmin;
          qmax_n  = Qmax;
          runs_n  = runs;
          mode_n  = mode;
          col_n   = '0;
          drain_n = 1'b0;
          sweep_n = '0;
          spin_n  = '0;
          iter_n  = '0;
          run_n   = '0;
        end
      end
      S_RESET: begin
        q_n     = q_init_c;
        state_n = S_MULT;
      end
      S_MULT: begin
        drain_n = 1'b0;
        if (col_q == LAST_IDX) begin
          col_n   = '0;
          state_n = S_LMULT;
        end else begin
          col_n = col_q + SPIN_W'(1);
        end
      end
      // Two drain cycles cover the BRAM read and the multiply stage.
      S_LMULT: begin
        if (drain_q) state_n = S_UPDATE;
        else         drain_n = 1'b1;
      end
      S_UPDATE: begin
        state_n = S_MULT;
        if (count_spin != LAST_IDX) begin
          spin_n = count_spin + SPIN_W'(1);
        end else begin
          spin_n = '0;
          iter_n = count_iter + ITER_WIDTH'(1);
          if ((sweep_q + 8'd1) == tau_eff) begin
            sweep_n = '0;
            if (Q == qmax_q) state_n = S_IRESET;
            else             q_n     = q_step_c;
          end else begin
            sweep_n = sweep_q + 8'd1;
          end
        end
      end
      S_IRESET: begin
        q_n     = q_init_c;
        iter_n  = '0;
        sweep_n = '0;
        if (run_idx == last_run) begin
          state_n = S_FIN;
        end else begin
          run_n   = run_idx + 8'd1;
          state_n = S_MULT;
        end
      end
      S_FIN: begin
        if (!comp_en) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) state_n = S_IDLE;
  end

  // State, datapath and strobe registers; strobes decode the next state so
  // each one is high exactly while the FSM sits in its state.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_q    <= S_IDLE;
      comp_en_q  <= 1'b1;  // a level held high through reset is not an edge
      col_q      <= '0;
      drain_q    <= 1'b0;
      sweep_q    <= '0;
      count_spin <= '0;
      count_iter <= '0;
      count_addr <= '0;
      Q          <= '0;
      run_idx    <= '0;
      tau_q      <= '0;
      beta_q     <= '0;
      qmin_q     <= '0;
      qmax_q     <= '0;
      runs_q     <= '0;
      mode_q     <= 1'b0;
      en_read    <= 1'b0;
      en_mult    <= 1'b0;
      en_upd     <= 1'b0;
      rst_iter   <= 1'b0;
      rst_ini    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_n;
      comp_en_q  <= comp_en;
      col_q      <= col_n;
      drain_q    <= drain_n;
      sweep_q    <= sweep_n;
      count_spin <= spin_n;
      count_iter <= iter_n;
      count_addr <= (ADDR_W'(spin_n) * N_A) + ADDR_W'(col_n);
      Q          <= q_n;
      run_idx    <= run_n;
      tau_q      <= tau_n;
      beta_q     <= beta_n;
      qmin_q     <= qmin_n;
      qmax_q     <= qmax_n;
      runs_q     <= runs_n;
      mode_q     <= mode_n;
      en_read    <= (state_n == S_MULT);
      en_mult    <= (state_n == S_MULT) || (state_n == S_LMULT);
      en_upd     <= (state_n == S_UPDATE);
      rst_iter   <= (state_n == S_IRESET);
      rst_ini    <= (state_n == S_RESET);
      busy       <= (state_n != S_IDLE) && (state_n != S_FIN);
      done       <= (state_n == S_FIN);
    end
  end

endmodule
